// File: rtl/uart_pkg.sv
// uart_pkg: receiver FSM state encoding and parity mode codes.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter with clear; mid_tick at the mid-bit decision count, end_tick at period end.
// UART_RX_MAJORITY_EN moves mid_tick one count later so the 3-sample vote window is complete.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic mid_tick,
  output logic end_tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [W-1:0] MID = W'(CLKS_PER_BIT / 2);
`else
  localparam logic [W-1:0] MID = W'(CLKS_PER_BIT / 2 - 1);
`endif
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (clr || cnt == LAST) ? '0 : cnt + 1'b1;
  assign mid_tick = cnt == MID;
  assign end_tick = cnt == LAST;
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receiver with mid-bit sampling, optional parity, 1/2 stop bits and a valid/ready holding register.
// UART_RX_MAJORITY_EN enables 2-of-3 voting around each mid-bit sample.
module uart_rx_core import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int BW = $clog2(DATA_BITS + 1);
  state_t state, nxt;
  logic s1, rxs, bitv, mid_tick, end_tick, clr, commit, perr, ferr;
  logic [BW-1:0] bcnt;
  logic [DATA_BITS-1:0] shift;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk), .reset(reset), .clr(clr), .mid_tick(mid_tick), .end_tick(end_tick)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;
  always_ff @(posedge clk or negedge reset)
    if (!reset) hist <= '1;
    else hist <= {hist[0], rxs};
  assign bitv = (rxs & hist[0]) | (rxs & hist[1]) | (hist[0] & hist[1]);
`else
  assign bitv = rxs;
`endif

  always_comb begin
    nxt = state;
    clr = 1'b0;
    case (state)
      IDLE:  if (!rxs) begin nxt = START; clr = 1'b1; end
      START: if (mid_tick) begin nxt = bitv ? IDLE : DATA; clr = 1'b1; end
      DATA:  if (end_tick && bcnt == BW'(DATA_BITS - 1)) nxt = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
      uart_pkg::PARITY: if (end_tick) nxt = STOP;
      STOP:  if (end_tick && bcnt == BW'(STOP_BITS - 1)) nxt = bitv ? IDLE : BRK;
      BRK:   if (rxs) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1     <= 1'b1;
      rxs    <= 1'b1;
      state  <= IDLE;
      bcnt   <= '0;
      shift  <= '1;
      perr   <= 1'b0;
      ferr   <= 1'b0;
      commit <= 1'b0;
    end else begin
      s1     <= rxd;
      rxs    <= s1;
      state  <= nxt;
      commit <= state == STOP && nxt != STOP;
      if (clr) bcnt <= '0;
      else if (end_tick && (state == DATA || state == STOP)) bcnt <= (nxt == state) ? bcnt + 1'b1 : '0;
      if (state == IDLE) begin
        perr <= 1'b0;
        ferr <= 1'b0;
      end
      if (state == DATA && end_tick) shift <= {bitv, shift[DATA_BITS-1:1]};
      if (state == uart_pkg::PARITY && end_tick) perr <= (^shift ^ bitv) != (PARITY == PAR_ODD);
      if (state == STOP && end_tick && !bitv) ferr <= 1'b1;
    end

  // A full, unconsumed holding register keeps its frame; the new one is dropped.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= commit && rx_valid && !rx_ready;
      if (commit && (!rx_valid || rx_ready)) begin
        rx_data    <= shift;
        parity_err <= perr;
        frame_err  <= ferr;
        rx_valid   <= 1'b1;
      end else if (rx_ready) rx_valid <= 1'b0;
    end

  assign busy = state != IDLE;
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: table-driven, corner-case and random-frame checks of uart_rx_core (8 data bits, even parity, 1 stop).
module tb_uart_rx_core;
  localparam int C = 16;
  logic clk = 1'b0, reset = 1'b0, rxd = 1'b1, rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, parity_err, frame_err, overrun, busy;
  int total = 0, bad = 0, vcyc = 0, ovr = 0;
  logic pv = 1'b0, pr = 1'b0;
  logic [9:0] got[$], exp_q[$];
  typedef struct {logic [7:0] d; logic p; logic s; logic pe; logic fe;} vec_t;
  vec_t tbl[9];

  always #5 clk = ~clk;

  uart_rx_core #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  // Accepted frames are recorded as {data, parity_err, frame_err}.
  always @(negedge clk) begin
    if (reset && pv && !pr) chk("valid_hold", {31'd0, rx_valid}, 1);
    if (rx_valid && rx_ready) got.push_back({rx_data, parity_err, frame_err});
    if (rx_valid) vcyc++;
    if (overrun) ovr++;
    pv = rx_valid;
    pr = rx_ready;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] d, input logic p, input logic s, input int glitch, input int gap, input int nbits);
    logic [10:0] b;
    b = {s, p, d, 1'b0};
    for (int i = 0; i < nbits; i++)
      for (int c = 0; c < C; c++) begin
        rxd = (i == glitch && c == C / 2) ? ~b[i] : b[i];
        step(1);
      end
    rxd = 1'b1;
    step(gap * C);
  endtask

  task automatic pop(output logic [9:0] f);
    if (got.size() > 0) f = got.pop_front();
    else f = '1;
  endtask

  task automatic wait_frame(input string n, output logic [9:0] f);
    int k;
    k = 0;
    while (got.size() == 0 && k < 4 * C) begin step(1); k++; end
    if (got.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: no frame within %0d clks", n, 4 * C);
      f = '1;
    end else f = got.pop_front();
  endtask

  initial begin
    logic [9:0] f, e;
    logic [7:0] d;
    logic p, s;
    int v0, o0, k, gap;
    tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{8'h7F, 1'b0, 1'b1, 1'b1, 1'b0};

    step(3);
    chk("rst_data", {24'd0, rx_data}, 0);
    chk("rst_valid", {31'd0, rx_valid}, 0);
    chk("rst_flags", {30'd0, parity_err, frame_err}, 0);
    chk("rst_ovr_busy", {30'd0, overrun, busy}, 0);
    reset = 1'b1;
    step(2 * C);

    for (int i = 0; i < 9; i++) begin
      v0 = vcyc;
      send(tbl[i].d, tbl[i].p, tbl[i].s, -1, 2, 11);
      wait_frame("tbl_wait", f);
      chk("tbl_data", {24'd0, f[9:2]}, {24'd0, tbl[i].d});
      chk("tbl_perr", {31'd0, f[1]}, {31'd0, tbl[i].pe});
      chk("tbl_ferr", {31'd0, f[0]}, {31'd0, tbl[i].fe});
      chk("tbl_vcyc", vcyc - v0, 1);
    end

    rxd = 1'b0;
    step(4);
    rxd = 1'b1;
    chk("fs_busy_on", {31'd0, busy}, 1);
    k = 0;
    while (busy && k < C / 2 + 3) begin step(1); k++; end
    chk("fs_busy_off", {31'd0, busy}, 0);
    step(2 * C);
    chk("fs_none", got.size(), 0);

    send(8'h5A, 1'b0, 1'b0, -1, 0, 10);
    rxd = 1'b0;
    step(41 * C);
    rxd = 1'b1;
    step(2 * C);
    send(8'h11, 1'b0, 1'b1, -1, 2, 11);
    step(C);
    chk("brk_count", got.size(), 2);
    pop(f);
    chk("brk_first", {22'd0, f}, {22'd0, 8'h5A, 2'b01});
    pop(f);
    chk("brk_second", {22'd0, f}, {22'd0, 8'h11, 2'b00});

    rx_ready = 1'b0;
    o0 = ovr;
    send(8'h3C, 1'b0, 1'b1, -1, 0, 11);
    send(8'hC3, 1'b0, 1'b1, -1, 2, 11);
    chk("ovr_valid", {31'd0, rx_valid}, 1);
    chk("ovr_data", {24'd0, rx_data}, 32'h3C);
    chk("ovr_pulses", ovr - o0, 1);
    chk("ovr_flags", {30'd0, parity_err, frame_err}, 0);
    rx_ready = 1'b1;
    step(2);
    chk("ovr_cleared", {31'd0, rx_valid}, 0);
    chk("ovr_count", got.size(), 1);
    pop(f);
    chk("ovr_frame", {22'd0, f}, {22'd0, 8'h3C, 2'b00});

    send(8'hFF, 1'b0, 1'b1, -1, 0, 5);
    reset = 1'b0;
    rxd = 1'b1;
    step(2);
    chk("ar_valid", {31'd0, rx_valid}, 0);
    chk("ar_data", {24'd0, rx_data}, 0);
    chk("ar_busy_ovr", {30'd0, busy, overrun}, 0);
    chk("ar_flags", {30'd0, parity_err, frame_err}, 0);
    reset = 1'b1;
    step(2 * C);
    send(8'h81, 1'b0, 1'b1, -1, 2, 11);
    step(C);
    chk("ar_count", got.size(), 1);
    pop(f);
    chk("ar_frame", {22'd0, f}, {22'd0, 8'h81, 2'b00});

    send(8'hFF, 1'b0, 1'b1, 4, 2, 11);
    wait_frame("gl_wait", f);
`ifdef UART_RX_MAJORITY_EN
    e = {8'hFF, 2'b00};
`else
    e = {8'hF7, 2'b10};
`endif
    chk("glitch", {22'd0, f}, {22'd0, e});

    got.delete();
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      p = 1'($urandom);
      s = $urandom_range(0, 4) != 0;
      gap = s ? $urandom_range(0, 2) : $urandom_range(1, 2);
      exp_q.push_back({d, ^{d, p}, ~s});
      send(d, p, s, -1, gap, 11);
    end
    step(4 * C);
    chk("rnd_count", got.size(), exp_q.size());
    while (exp_q.size() > 0 && got.size() > 0) begin
      e = exp_q.pop_front();
      f = got.pop_front();
      chk("rnd_frame", {22'd0, f}, {22'd0, e});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
